// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command sequencer: FSM states, error codes, frame fields.
// No logic, no latency; a types-only package.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CHK     = 2'd1,
        ERR_ADDR    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } frame_t;

    // Checksum is the 8-bit wrapping sum of address and data.
    function automatic logic [7:0] frame_sum(input frame_t f);
        return f.addr + f.data;
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Rising-edge detector on a UART "byte ready" level; strobe is combinational in the edge cycle.
// No backpressure: a level held high yields a single strobe, and a low cycle re-arms it.
module uart_byte_strobe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       strobe,
    output logic [7:0] data
);

    logic rdy_q;

    // Resetting to 1 means a level already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= rx_ready;
        end
    end

    assign strobe = rx_ready & ~rdy_q;
    assign data   = rx_data;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame (hdr, addr, data, chk) to register-write sequencer; results registered one cycle after the last strobe.
// No backpressure; optional saturating error counter on err_cnt_o under UART_CMD_STATS_EN.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_REGS    = 4,
    parameter int         TIMEOUT_CYC = 500000,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  rx_data_i,
    input  logic                        rx_ready_i,
    output logic [NUM_REGS*8-1:0]       regs_o,
    output logic                        reg_we_o,
    output logic [$clog2(NUM_REGS)-1:0] reg_addr_o,
    output logic                        cmd_ok_o,
    output logic                        cmd_err_o,
    output logic [1:0]                  err_code_o,
    output logic                        busy_o
`ifdef UART_CMD_STATS_EN
    ,
    output logic [7:0]                  err_cnt_o
`endif
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic                     strobe;
    logic [7:0]               rx_byte;
    state_t                   state, state_nxt;
    frame_t                   frame;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic                     timeout, accept, reject;
    err_code_t                rej_code;
    logic [NUM_REGS-1:0][7:0] bank;
    logic [AW-1:0]            wr_idx;

    uart_byte_strobe u_strobe (
        .clk      (clk_i),
        .rst      (rst_i),
        .rx_data  (rx_data_i),
        .rx_ready (rx_ready_i),
        .strobe   (strobe),
        .data     (rx_byte)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign cnt_nxt = cnt + CW'(1);
    assign wr_idx  = frame.addr[AW-1:0];

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        rej_code  = ERR_NONE;
        case (state)
            S_IDLE: if (strobe && rx_byte == HDR_BYTE) state_nxt = S_ADDR;
            S_ADDR: if (strobe) state_nxt = S_DATA;
            S_DATA: if (strobe) state_nxt = S_CHK;
            S_CHK: begin
                if (strobe) begin
                    state_nxt = S_IDLE;
                    if (rx_byte != frame_sum(frame)) begin
                        reject   = 1'b1;
                        rej_code = ERR_CHK;
                    end else if (int'(frame.addr) >= NUM_REGS) begin
                        reject   = 1'b1;
                        rej_code = ERR_ADDR;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Error is registered on the same edge the counter reaches terminal count; a strobe wins.
        if (state != S_IDLE && !strobe && cnt_nxt == CW'(TIMEOUT_CYC - 1)) begin
            timeout   = 1'b1;
            state_nxt = S_IDLE;
            reject    = 1'b1;
            rej_code  = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt        <= '0;
            frame      <= '0;
            bank       <= '0;
            reg_we_o   <= 1'b0;
            reg_addr_o <= '0;
            cmd_ok_o   <= 1'b0;
            cmd_err_o  <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            reg_we_o  <= 1'b0;
            cmd_ok_o  <= 1'b0;
            cmd_err_o <= 1'b0;
            if (strobe || timeout) begin
                cnt <= '0;
            end else if (state != S_IDLE) begin
                cnt <= cnt_nxt;
            end
            if (strobe && state == S_ADDR) frame.addr <= rx_byte;
            if (strobe && state == S_DATA) frame.data <= rx_byte;
            if (accept) begin
                bank[wr_idx] <= frame.data;
                reg_we_o     <= 1'b1;
                cmd_ok_o     <= 1'b1;
                reg_addr_o   <= wr_idx;
            end
            if (reject) begin
                cmd_err_o  <= 1'b1;
                err_code_o <= rej_code;
            end
        end
    end

`ifdef UART_CMD_STATS_EN
    // Counter moves on the same edge that raises cmd_err_o so both are visible together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (reject && err_cnt_o != 8'hFF) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

    assign regs_o = bank;
    assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with NUM_REGS=4, TIMEOUT_CYC=100; outputs sampled on the falling edge.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] regs;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic        cmd_ok;
    logic        cmd_err;
    logic [1:0]  err_code;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int ok_cnt = 0;
    int err_cnt = 0;

    uart_cmd_ctrl #(
        .NUM_REGS    (4),
        .TIMEOUT_CYC (100),
        .HDR_BYTE    (8'hA5)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_ready_i (rx_ready),
        .regs_o     (regs),
        .reg_we_o   (reg_we),
        .reg_addr_o (reg_addr),
        .cmd_ok_o   (cmd_ok),
        .cmd_err_o  (cmd_err),
        .err_code_o (err_code),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_we === 1'b1) we_cnt++;
        if (cmd_ok === 1'b1) ok_cnt++;
        if (cmd_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One byte: ready high for hi_cyc cycles then low; flags are the outputs one cycle after the strobe.
    task automatic send_byte(input logic [7:0] b, input int hi_cyc,
                             output logic we1, output logic ok1, output logic err1);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        we1  = reg_we;
        ok1  = cmd_ok;
        err1 = cmd_err;
        repeat (hi_cyc - 1) @(negedge clk);
        rx_ready = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, output logic we1, output logic ok1, output logic err1);
        logic w, o, e;
        send_byte(a, 10, w, o, e);
        send_byte(b, 10, w, o, e);
        send_byte(c, 10, w, o, e);
        send_byte(d, 10, we1, ok1, err1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic we1, ok1, err1, bsy99, found;
        logic [1:0] code_at;
        logic bsy_at;
        int k, w0, o0, e0;

        // Ready already high across reset release must not start a frame.
        rst = 1'b1;
        rx_ready = 1'b1;
        rx_data = 8'hA5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_regs", regs, 32'h0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_pulses", 32'(we_cnt + ok_cnt + err_cnt), 32'd0);
        rx_ready = 1'b0;
        repeat (5) @(negedge clk);

        // Good write to reg2.
        w0 = we_cnt;
        send_frame(8'hA5, 8'h02, 8'h3C, 8'h3E, we1, ok1, err1);
        check("f1_we", 32'(we1), 32'd1);
        check("f1_ok", 32'(ok1), 32'd1);
        check("f1_err", 32'(err1), 32'd0);
        check("f1_addr", 32'(reg_addr), 32'd2);
        check("f1_regs", regs, 32'h003C_0000);
        check("f1_err_code", 32'(err_code), 32'd0);
        check("f1_we_single", 32'(we_cnt - w0), 32'd1);

        // Bad checksum, then a good frame that leaves the error code alone.
        w0 = we_cnt;
        send_frame(8'hA5, 8'h01, 8'h10, 8'h00, we1, ok1, err1);
        check("f2_err", 32'(err1), 32'd1);
        check("f2_ok", 32'(ok1), 32'd0);
        check("f2_err_code", 32'(err_code), 32'd1);
        check("f2_regs", regs, 32'h003C_0000);
        send_frame(8'hA5, 8'h01, 8'h10, 8'h11, we1, ok1, err1);
        check("f3_ok", 32'(ok1), 32'd1);
        check("f3_regs", regs, 32'h003C_1000);
        check("f3_err_code_kept", 32'(err_code), 32'd1);
        check("f3_addr", 32'(reg_addr), 32'd1);

        // Valid checksum, out-of-range address.
        w0 = we_cnt;
        send_frame(8'hA5, 8'h05, 8'h11, 8'h16, we1, ok1, err1);
        check("f4_err", 32'(err1), 32'd1);
        check("f4_err_code", 32'(err_code), 32'd2);
        check("f4_no_we", 32'(we_cnt - w0), 32'd0);

        // Header and address, then silence.
        send_byte(8'hA5, 10, we1, ok1, err1);
        @(negedge clk);
        rx_data  = 8'h01;
        rx_ready = 1'b1;
        found = 1'b0;
        k = 0;
        bsy99 = 1'b0;
        code_at = 2'd0;
        bsy_at = 1'b1;
        for (int i = 1; i <= 150 && !found; i++) begin
            @(negedge clk);
            if (i == 10) rx_ready = 1'b0;
            if (i == 99) bsy99 = busy;
            if (cmd_err) begin
                found = 1'b1;
                k = i;
                code_at = err_code;
                bsy_at = busy;
            end
        end
        check("to_cycle", 32'(k), 32'd100);
        check("to_busy_before", 32'(bsy99), 32'd1);
        check("to_err_code", 32'(code_at), 32'd3);
        check("to_busy_after", 32'(bsy_at), 32'd0);
        repeat (5) @(negedge clk);
        send_frame(8'hA5, 8'h00, 8'h55, 8'h55, we1, ok1, err1);
        check("to_next_ok", 32'(ok1), 32'd1);
        check("to_next_regs", regs, 32'h003C_1055);

        // Leading garbage, then a wrapping checksum.
        send_byte(8'h00, 10, we1, ok1, err1);
        send_byte(8'hFF, 10, we1, ok1, err1);
        check("garbage_busy", 32'(busy), 32'd0);
        send_frame(8'hA5, 8'h03, 8'hFF, 8'h02, we1, ok1, err1);
        check("wrap_ok", 32'(ok1), 32'd1);
        check("wrap_regs", regs, 32'hFF3C_1055);

        // Header held high for 50 cycles counts once.
        o0 = ok_cnt;
        send_byte(8'hA5, 50, we1, ok1, err1);
        check("hold_busy", 32'(busy), 32'd1);
        send_byte(8'h02, 10, we1, ok1, err1);
        send_byte(8'h77, 10, we1, ok1, err1);
        send_byte(8'h79, 10, we1, ok1, err1);
        check("hold_ok", 32'(ok_cnt - o0), 32'd1);
        check("hold_regs", regs, 32'hFF77_1055);

        // Reset mid-frame drops the frame silently.
        send_byte(8'hA5, 10, we1, ok1, err1);
        send_byte(8'h01, 10, we1, ok1, err1);
        check("mid_busy_before", 32'(busy), 32'd1);
        e0 = err_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_no_err", 32'(err_cnt - e0), 32'd0);
        check("mid_regs", regs, 32'h0);
        check("mid_err_code", 32'(err_code), 32'd0);
        check("mid_reg_addr", 32'(reg_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
